// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x16 register file plus an IDLE/READ_A/READ_B/ISSUE
// sequencer that presents Ain/Bin/ALUop to the ALU under a valid/ready handshake.
module operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [1:0]  shift,
    input  logic        asel,
    input  logic        bsel,
    input  logic [15:0] sximm5,
    input  logic [1:0]  ALUop_in,
    input  logic        w_en,
    input  logic [2:0]  w_num,
    input  logic [15:0] w_data,
    input  logic        ready,
    output logic [15:0] Ain,
    output logic [15:0] Bin,
    output logic [1:0]  ALUop,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        ISSUE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  rn_q, rm_q;
    logic [1:0]  shift_q;
    logic        asel_q, bsel_q;
    logic [15:0] imm_q;
    logic [1:0]  op_q;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] regs_q [8];
    logic [15:0] rm_val, rm_shifted;

    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = READ_A;
            READ_A:  state_d = READ_B;
            READ_B:  state_d = ISSUE;
            ISSUE:   if (ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rm_val     = regs_q[rm_q];
        rm_shifted = rm_val;
        unique case (shift_q)
            2'b00: rm_shifted = rm_val;
            2'b01: rm_shifted = {rm_val[14:0], 1'b0};
            2'b10: rm_shifted = {1'b0, rm_val[15:1]};
            2'b11: rm_shifted = {rm_val[15], rm_val[15:1]};
            default: rm_shifted = rm_val;
        endcase
        a_d = asel_q ? 16'h0000 : regs_q[rn_q];
        b_d = bsel_q ? imm_q : rm_shifted;
    end

    // NOTE: sequential state uses non-blocking assignments so a register read
    // on the same edge as its write sees the old value, as the datapath expects.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= '0;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            imm_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            // NOTE: the register file is small and must read as zero after
            // reset, so it is cleared here rather than mapped to a RAM macro.
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                rn_q    <= rn;
                rm_q    <= rm;
                shift_q <= shift;
                asel_q  <= asel;
                bsel_q  <= bsel;
                imm_q   <= sximm5;
                op_q    <= ALUop_in;
            end
            if (state_q == READ_A) a_q <= a_d;
            if (state_q == READ_B) b_q <= b_d;
            if (w_en) regs_q[w_num] <= w_data;
        end
    end

    // valid/busy decode the state register only; ready never reaches them.
    assign valid = (state_q == ISSUE);
    assign busy  = (state_q != IDLE);
    assign Ain   = a_q;
    assign Bin   = b_q;
    assign ALUop = op_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// fetches with concurrent register writes, checked against an array model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  rn, rm;
    logic [1:0]  shift;
    logic        asel, bsel;
    logic [15:0] sximm5;
    logic [1:0]  ALUop_in;
    logic        w_en;
    logic [2:0]  w_num;
    logic [15:0] w_data;
    logic        ready;
    logic [15:0] Ain, Bin;
    logic [1:0]  ALUop;
    logic        valid, busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] model_rf [8];
    bit rand_wr = 1'b0;

    operand_fetch dut (
        .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .shift(shift),
        .asel(asel), .bsel(bsel), .sximm5(sximm5), .ALUop_in(ALUop_in),
        .w_en(w_en), .w_num(w_num), .w_data(w_data), .ready(ready),
        .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] shift_ref(input logic [15:0] v, input logic [1:0] c);
        case (c)
            2'd0:    return v;
            2'd1:    return 16'(v * 2);
            2'd2:    return v / 2;
            default: return 16'($signed(v) >>> 1);
        endcase
    endfunction

    // One clock edge; the model register file follows the same edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
        end else if (w_en) begin
            model_rf[w_num] = w_data;
        end
        #1;
    endtask

    task automatic drive_write();
        if (rand_wr) begin
            w_en   = 1'($urandom_range(0, 1));
            w_num  = 3'($urandom);
            w_data = 16'($urandom);
        end else begin
            w_en = 1'b0;
        end
    endtask

    task automatic scramble_fields();
        rn = 3'($urandom); rm = 3'($urandom); shift = 2'($urandom);
        asel = 1'($urandom); bsel = 1'($urandom);
        sximm5 = 16'($urandom); ALUop_in = 2'($urandom);
    endtask

    task automatic write_reg(input logic [2:0] n, input logic [15:0] d);
        w_en = 1'b1; w_num = n; w_data = d;
        tick();
        w_en = 1'b0;
    endtask

    task automatic do_fetch(input logic [2:0] f_rn, input logic [2:0] f_rm,
                            input logic [1:0] f_shift, input logic f_asel,
                            input logic f_bsel, input logic [15:0] f_imm,
                            input logic [1:0] f_op, input int stall,
                            input logic wr_a, input logic [2:0] wr_num,
                            input logic [15:0] wr_data, input string name);
        logic [15:0] exp_a, exp_b;
        start = 1'b1; rn = f_rn; rm = f_rm; shift = f_shift;
        asel = f_asel; bsel = f_bsel; sximm5 = f_imm; ALUop_in = f_op;
        ready = 1'b0;
        drive_write();
        tick();
        // READ_A cycle: captured fields must no longer follow the inputs.
        start = 1'b0;
        scramble_fields();
        n_checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s read_a_status: busy=%b valid=%b expected busy=1 valid=0", name, busy, valid);
        end
        exp_a = f_asel ? 16'h0000 : model_rf[f_rn];
        if (wr_a) begin
            w_en = 1'b1; w_num = wr_num; w_data = wr_data;
        end else begin
            drive_write();
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s read_b_status: busy=%b valid=%b expected busy=1 valid=0", name, busy, valid);
        end
        exp_b = f_bsel ? f_imm : shift_ref(model_rf[f_rm], f_shift);
        drive_write();
        tick();
        for (int k = 0; k <= stall; k++) begin
            n_checks++;
            if (valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s issue_status[%0d]: valid=%b busy=%b expected 1 1", name, k, valid, busy);
            end
            n_checks++;
            if (Ain !== exp_a) begin
                n_fail++;
                $display("FAIL %s Ain[%0d]: got %h expected %h", name, k, Ain, exp_a);
            end
            n_checks++;
            if (Bin !== exp_b) begin
                n_fail++;
                $display("FAIL %s Bin[%0d]: got %h expected %h", name, k, Bin, exp_b);
            end
            n_checks++;
            if (ALUop !== f_op) begin
                n_fail++;
                $display("FAIL %s ALUop[%0d]: got %b expected %b", name, k, ALUop, f_op);
            end
            ready = (k == stall);
            start = (k == 1);
            scramble_fields();
            drive_write();
            tick();
        end
        start = 1'b0; ready = 1'b0; w_en = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back_to_idle: valid=%b busy=%b expected 0 0", name, valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ready = 1'b0; w_en = 1'b0; w_num = '0; w_data = '0;
        scramble_fields();
        tick();
        start = 1'b1; w_en = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0; w_en = 1'b0; ready = 1'b0;
        reset = 1'b0;
        n_checks++;
        if (Ain !== 16'h0 || Bin !== 16'h0 || ALUop !== 2'b00 || valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: Ain=%h Bin=%h ALUop=%b valid=%b busy=%b expected all zero",
                     Ain, Bin, ALUop, valid, busy);
        end
    endtask

    task automatic test_basic();
        write_reg(3'd1, 16'h0005);
        write_reg(3'd2, 16'h0003);
        do_fetch(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h1234, 2'b01, 0, 1'b0, 3'd0, 16'h0, "basic");
    endtask

    task automatic test_shifts();
        write_reg(3'd3, 16'h8001);
        do_fetch(3'd0, 3'd3, 2'b01, 1'b0, 1'b0, 16'h0, 2'b10, 0, 1'b0, 3'd0, 16'h0, "shift_left");
        do_fetch(3'd0, 3'd3, 2'b10, 1'b0, 1'b0, 16'h0, 2'b11, 0, 1'b0, 3'd0, 16'h0, "shift_lsr");
        do_fetch(3'd0, 3'd3, 2'b11, 1'b0, 1'b0, 16'h0, 2'b00, 0, 1'b0, 3'd0, 16'h0, "shift_asr");
    endtask

    task automatic test_source_select();
        write_reg(3'd5, 16'hABCD);
        do_fetch(3'd5, 3'd5, 2'b11, 1'b1, 1'b1, 16'hFFF0, 2'b11, 0, 1'b0, 3'd0, 16'h0, "source_select");
    endtask

    task automatic test_backpressure();
        do_fetch(3'd1, 3'd3, 2'b01, 1'b0, 1'b0, 16'h0, 2'b10, 4, 1'b0, 3'd0, 16'h0, "backpressure");
    endtask

    task automatic test_collision();
        write_reg(3'd4, 16'h1111);
        do_fetch(3'd4, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, 0, 1'b1, 3'd4, 16'h2222, "collision");
        do_fetch(3'd4, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01, 0, 1'b0, 3'd0, 16'h0, "collision_after");
        n_checks++;
        if (Ain !== 16'h2222) begin
            n_fail++;
            $display("FAIL collision_new_value: got %h expected 2222", Ain);
        end
    endtask

    task automatic test_reset_mid();
        write_reg(3'd1, 16'h1234);
        start = 1'b1; rn = 3'd1; rm = 3'd1; shift = 2'b00; asel = 1'b0; bsel = 1'b0;
        ALUop_in = 2'b11; ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || Ain !== 16'h0 || Bin !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b valid=%b Ain=%h Bin=%h expected all zero", busy, valid, Ain, Bin);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_handshake: valid=%b expected 0", valid);
        end
        ready = 1'b0;
        do_fetch(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 0, 1'b0, 3'd0, 16'h0, "reset_mid_r1");
        n_checks++;
        if (Ain !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_r1_cleared: got %h expected 0000", Ain);
        end
    endtask

    task automatic test_random();
        rand_wr = 1'b1;
        for (int i = 0; i < 8; i++) write_reg(3'(i), 16'($urandom));
        for (int n = 0; n < 30; n++) begin
            do_fetch(3'($urandom), 3'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 3) == 0), 16'($urandom), 2'($urandom),
                     int'($urandom_range(0, 3)), 1'($urandom), 3'($urandom), 16'($urandom), "random");
        end
        rand_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shifts();
        test_source_select();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
